// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] data_t;
   typedef logic [3:0]  be_t;

   typedef enum logic [1:0] {StIdle, StAccess, StDone} arb_state_t;

   localparam int unsigned MemLatencyDefault = 1;

   // Word access needs a word-aligned address, halfword lanes need an even one.
   function automatic logic is_misaligned(input logic [1:0] addr_lo, input be_t be);
      logic mis;
      mis = 1'b0;
      if (be == 4'hF) begin
         mis = (addr_lo != 2'b00);
      end else if (be == 4'h3 || be == 4'hC) begin
         mis = addr_lo[0];
      end
      return mis;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled with modports.
interface mem_port_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   import mem_port_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_we;
   addr_t              req_addr  [NUM_REQ];
   data_t              req_wdata [NUM_REQ];
   be_t                req_be    [NUM_REQ];
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] done;
   logic               err;
   data_t              rdata;
   addr_t              mem_addr;
   data_t              mem_wdata;
   be_t                mem_be;
   logic               mem_we;
   data_t              mem_rdata;
   logic               busy;

   modport slave (
      input  req, req_we, req_addr, req_wdata, req_be, mem_rdata,
      output gnt, done, err, rdata, mem_addr, mem_wdata, mem_be, mem_we, busy
   );

   modport master (
      output req, req_we, req_addr, req_wdata, req_be, mem_rdata,
      input  gnt, done, err, rdata, mem_addr, mem_wdata, mem_be, mem_we, busy
   );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational winner selection: fixed core priority or round-robin after last grant.
module rr_picker #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    last_grant_i,
   input  logic               core_priority_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   logic            found;
   logic [IdxW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      if (core_priority_i && req_i[0]) begin
         gnt_o[0] = 1'b1;
      end else begin
         // Search starts one past the last owner and wraps.
         for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = IdxW'((32'(last_grant_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
               gnt_o[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between NUM_REQ requesters, one transaction at a time.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 2,
   parameter int unsigned MEM_LATENCY   = MemLatencyDefault,
   parameter bit          CORE_PRIORITY = 1'b0
) (
   input logic              clk,
   input logic              reset,
   mem_port_arbiter_if.slave bus_io
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [CntW-1:0] cnt_t;

   localparam idx_t LastInit = idx_t'(NUM_REQ - 1);
   localparam cnt_t ReadCnt  = cnt_t'(MEM_LATENCY - 1);

   arb_state_t         state_q, state_d;
   idx_t               g_q, g_d;
   idx_t               last_q, last_d;
   logic               we_q, we_d;
   logic [29:0]        waddr_q, waddr_d;
   data_t              wdata_q, wdata_d;
   be_t                be_q, be_d;
   logic               err_q, err_d;
   cnt_t               cnt_q, cnt_d;
   data_t              rdata_q, rdata_d;

   logic [NUM_REQ-1:0] pick;
   idx_t               pick_idx;
   logic               any_req;
   logic               pick_mis;

   rr_picker #(
      .NUM_REQ(NUM_REQ)
   ) u_picker (
      .req_i           (bus_io.req),
      .last_grant_i    (last_q),
      .core_priority_i (CORE_PRIORITY),
      .gnt_o           (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = idx_t'(i);
      end
   end

   assign any_req  = |bus_io.req;
   assign pick_mis = is_misaligned(bus_io.req_addr[pick_idx][1:0], bus_io.req_be[pick_idx]);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (any_req) state_d = pick_mis ? StDone : StAccess;
         StAccess: if (cnt_q == '0) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Transaction latches, counter and read-data capture.
   always_comb begin
      g_d     = g_q;
      last_d  = last_q;
      we_d    = we_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               g_d     = pick_idx;
               we_d    = bus_io.req_we[pick_idx];
               waddr_d = bus_io.req_addr[pick_idx][31:2];
               wdata_d = bus_io.req_wdata[pick_idx];
               be_d    = bus_io.req_be[pick_idx];
               err_d   = pick_mis;
               cnt_d   = bus_io.req_we[pick_idx] ? '0 : ReadCnt;
            end
         end
         StAccess: begin
            if (cnt_q == '0) begin
               if (!we_q) rdata_d = bus_io.mem_rdata;
            end else begin
               cnt_d = cnt_q - cnt_t'(1);
            end
         end
         StDone:  last_d = g_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         g_q     <= '0;
         last_q  <= LastInit;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         g_q     <= g_d;
         last_q  <= last_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode from state so reset clears strobes without waiting for a clock.
   always_comb begin
      bus_io.busy      = (state_q != StIdle);
      bus_io.gnt       = (state_q != StIdle) ? (NUM_REQ'(1) << g_q) : '0;
      bus_io.done      = (state_q == StDone) ? (NUM_REQ'(1) << g_q) : '0;
      bus_io.err       = (state_q == StDone) && err_q;
      bus_io.mem_we    = (state_q == StAccess) && we_q;
      bus_io.rdata     = rdata_q;
      bus_io.mem_addr  = {waddr_q, 2'b00};
      bus_io.mem_wdata = wdata_q;
      bus_io.mem_be    = be_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin and a core-priority arbiter share stimulus, each with its own memory.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned Lat = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mem_clear = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] req = '0;
   logic [1:0] req_we = '0;
   addr_t      req_addr [2];
   data_t      req_wdata [2];
   be_t        req_be [2];

   data_t mem_r [256];
   data_t mem_p [256];

   int total = 0;
   int bad = 0;

   mem_port_arbiter_if #(.NUM_REQ(2)) bus_r ();
   mem_port_arbiter_if #(.NUM_REQ(2)) bus_p ();

   mem_port_arbiter #(.NUM_REQ(2), .MEM_LATENCY(Lat), .CORE_PRIORITY(1'b0)) dut_r (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus_r)
   );

   mem_port_arbiter #(.NUM_REQ(2), .MEM_LATENCY(Lat), .CORE_PRIORITY(1'b1)) dut_p (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus_p)
   );

   always_comb begin
      bus_r.req = req;  bus_r.req_we = req_we;  bus_r.req_addr = req_addr;
      bus_r.req_wdata = req_wdata;  bus_r.req_be = req_be;
      bus_p.req = req;  bus_p.req_we = req_we;  bus_p.req_addr = req_addr;
      bus_p.req_wdata = req_wdata;  bus_p.req_be = req_be;
   end

   assign bus_r.mem_rdata = mem_r[bus_r.mem_addr[9:2]];
   assign bus_p.mem_rdata = mem_p[bus_p.mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) begin
            mem_r[i] <= '0;
            mem_p[i] <= '0;
         end
         mem_r[8'h40] <= 32'hDEADBEEF;
         mem_p[8'h40] <= 32'hDEADBEEF;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (bus_r.mem_we && bus_r.mem_be[b])
               mem_r[bus_r.mem_addr[9:2]][8*b +: 8] <= bus_r.mem_wdata[8*b +: 8];
            if (bus_p.mem_we && bus_p.mem_be[b])
               mem_p[bus_p.mem_addr[9:2]][8*b +: 8] <= bus_p.mem_wdata[8*b +: 8];
         end
      end
   end

   // Issues one request on the shared inputs and observes dut_r for a fixed 8-cycle window.
   task automatic run_txn(input logic port, input logic we, input addr_t addr, input data_t wdata,
                          input be_t be, input int drop_k,
                          output int done_k, output int pulses, output int we_cycles,
                          output int busy_cycles, output addr_t we_addr, output logic err_s,
                          output data_t rdata_s, output logic [1:0] gnt1);
      @(negedge clk);
      req_we[port] = we;  req_addr[port] = addr;  req_wdata[port] = wdata;
      req_be[port] = be;  req[port] = 1'b1;
      done_k = 0;  pulses = 0;  we_cycles = 0;  busy_cycles = 0;
      we_addr = '0;  err_s = 1'b0;  rdata_s = '0;  gnt1 = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) gnt1 = bus_r.gnt;
         if (bus_r.mem_we) begin
            we_cycles++;
            we_addr = bus_r.mem_addr;
         end
         if (bus_r.busy) busy_cycles++;
         if (bus_r.done != 2'b00) begin
            pulses++;
            if (done_k == 0 && bus_r.done[port]) begin
               done_k = k;  err_s = bus_r.err;  rdata_s = bus_r.rdata;
            end
         end
         if (k == drop_k || bus_r.done[port]) req[port] = 1'b0;
      end
      req[port] = 1'b0;
   endtask

   int         dk, np, nw, nb;
   addr_t      wa;
   logic       es;
   data_t      rs;
   logic [1:0] g1;

   task automatic test_reset();
      reset = 1'b1;  mem_clear = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({bus_r.gnt, bus_r.done, bus_r.err, bus_r.busy, bus_r.mem_we} !== 7'd0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=0", {bus_r.gnt, bus_r.done, bus_r.err,
                  bus_r.busy, bus_r.mem_we});
      end
      total++;
      if (bus_r.rdata !== 32'h0) begin
         bad++;  $display("FAIL reset_rdata got=%h want=0", bus_r.rdata);
      end
      total++;
      if ({bus_r.mem_addr, bus_r.mem_wdata, bus_r.mem_be} !== 68'h0) begin
         bad++;
         $display("FAIL reset_mem got=%h/%h/%h want=0", bus_r.mem_addr, bus_r.mem_wdata,
                  bus_r.mem_be);
      end
      reset = 1'b0;  mem_clear = 1'b0;
   endtask

   task automatic test_single_read();
      run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (dk !== Lat + 1) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", dk, Lat + 1); end
      total++;
      if (rs !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rs); end
      total++;
      if (es !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", es); end
      total++;
      if (np !== 1) begin bad++; $display("FAIL rd_pulses got=%0d want=1", np); end
      total++;
      if (nb !== Lat + 1) begin bad++; $display("FAIL rd_busy got=%0d want=%0d", nb, Lat + 1); end
      total++;
      if (g1 !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b want=01", g1); end
   endtask

   task automatic test_single_write();
      run_txn(1'b1, 1'b1, 32'h204, 32'h12345678, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (dk !== 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", dk); end
      total++;
      if (nw !== 1) begin bad++; $display("FAIL wr_we_cycles got=%0d want=1", nw); end
      total++;
      if (wa !== 32'h204) begin bad++; $display("FAIL wr_mem_addr got=%h want=204", wa); end
      total++;
      if (rs !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata_hold got=%h want=deadbeef", rs); end
      run_txn(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (rs !== 32'h12345678) begin bad++; $display("FAIL wr_readback got=%h want=12345678", rs); end
      total++;
      if (nw !== 0) begin bad++; $display("FAIL rd_no_we got=%0d want=0", nw); end
      // Upper-halfword write only touches lanes 3:2.
      run_txn(1'b1, 1'b1, 32'h206, 32'h9ABCDEF0, 4'hC, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (mem_r[8'h81] !== 32'h9ABC5678) begin
         bad++;  $display("FAIL wr_be_lanes got=%h want=9abc5678", mem_r[8'h81]);
      end
      total++;
      if (wa !== 32'h204) begin bad++; $display("FAIL wr_be_addr got=%h want=204", wa); end
      run_txn(1'b0, 1'b0, 32'h204, 32'h0, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (rs !== 32'h9ABC5678) begin bad++; $display("FAIL wr_be_readback got=%h want=9abc5678", rs); end
   endtask

   task automatic test_misaligned();
      run_txn(1'b0, 1'b0, 32'h102, 32'h0, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (dk !== 1) begin bad++; $display("FAIL mis_latency got=%0d want=1", dk); end
      total++;
      if (es !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", es); end
      total++;
      if (nw !== 0) begin bad++; $display("FAIL mis_we got=%0d want=0", nw); end
      total++;
      if (nb !== 1) begin bad++; $display("FAIL mis_busy got=%0d want=1", nb); end
      total++;
      if (rs !== 32'h9ABC5678) begin bad++; $display("FAIL mis_rdata_hold got=%h want=9abc5678", rs); end
      run_txn(1'b1, 1'b0, 32'h101, 32'h0, 4'hC, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (es !== 1'b1 || dk !== 1) begin
         bad++;  $display("FAIL mis_half got=err%b/k%0d want=err1/k1", es, dk);
      end
      run_txn(1'b0, 1'b0, 32'h102, 32'h0, 4'h3, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (es !== 1'b0 || dk !== Lat + 1 || rs !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL half_aligned got=err%b/k%0d/%h want=err0/k%0d/deadbeef", es, dk, rs, Lat + 1);
      end
   endtask

   task automatic test_dropped_req();
      run_txn(1'b1, 1'b1, 32'h208, 32'hCAFEF00D, 4'hF, 1, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (dk !== 2 || np !== 1) begin
         bad++;  $display("FAIL drop_done got=k%0d/n%0d want=k2/n1", dk, np);
      end
      total++;
      if (mem_r[8'h82] !== 32'hCAFEF00D) begin
         bad++;  $display("FAIL drop_write got=%h want=cafef00d", mem_r[8'h82]);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(negedge clk);
      req_we[0] = 1'b1;  req_addr[0] = 32'h300;  req_wdata[0] = 32'hBAD0BAD0;
      req_be[0] = 4'hF;  req[0] = 1'b1;
      @(negedge clk);
      total++;
      if (bus_r.mem_we !== 1'b1) begin bad++; $display("FAIL rstmid_pre_we got=%b want=1", bus_r.mem_we); end
      reset = 1'b1;
      #1;
      total++;
      if ({bus_r.mem_we, bus_r.gnt, bus_r.busy} !== 4'b0) begin
         bad++;
         $display("FAIL rstmid_async got=we%b/gnt%b/busy%b want=0", bus_r.mem_we, bus_r.gnt,
                  bus_r.busy);
      end
      req[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus_r.done != 2'b00) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
      run_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 0, dk, np, nw, nb, wa, es, rs, g1);
      total++;
      if (dk !== Lat + 1 || rs !== 32'h0) begin
         bad++;  $display("FAIL rstmid_after got=k%0d/%h want=k%0d/00000000", dk, rs, Lat + 1);
      end
   endtask

   task automatic test_contention();
      int own_r [4];
      int own_p [4];
      int k_r [4];
      data_t rd_r [4];
      int nr, npr, multi;
      int exp_own [4];
      data_t exp_rd [4];
      exp_own = '{0, 1, 0, 1};
      exp_rd  = '{32'hDEADBEEF, 32'h9ABC5678, 32'hDEADBEEF, 32'h9ABC5678};
      nr = 0;  npr = 0;  multi = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req_we = 2'b00;
      req_addr[0] = 32'h100;  req_be[0] = 4'hF;
      req_addr[1] = 32'h204;  req_be[1] = 4'hF;
      req = 2'b11;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (!$onehot0(bus_r.gnt) || !$onehot0(bus_p.gnt)) multi++;
         if (bus_r.done != 2'b00 && nr < 4) begin
            own_r[nr] = bus_r.done[1] ? 1 : 0;  k_r[nr] = k;  rd_r[nr] = bus_r.rdata;  nr++;
         end
         if (bus_p.done != 2'b00 && npr < 4) begin
            own_p[npr] = bus_p.done[1] ? 1 : 0;  npr++;
         end
         if (nr == 4 && npr == 4) break;
      end
      req = 2'b00;
      total++;
      if (nr !== 4 || npr !== 4) begin
         bad++;  $display("FAIL cont_count got=%0d/%0d want=4/4", nr, npr);
      end
      for (int i = 0; i < nr; i++) begin
         total++;
         if (own_r[i] !== exp_own[i] || k_r[i] !== 3 + 4 * i || rd_r[i] !== exp_rd[i]) begin
            bad++;
            $display("FAIL rr_txn%0d got=p%0d/k%0d/%h want=p%0d/k%0d/%h", i, own_r[i], k_r[i],
                     rd_r[i], exp_own[i], 3 + 4 * i, exp_rd[i]);
         end
      end
      for (int i = 0; i < npr; i++) begin
         total++;
         if (own_p[i] !== 0) begin bad++; $display("FAIL pri_txn%0d got=p%0d want=p0", i, own_p[i]); end
      end
      total++;
      if (multi !== 0) begin bad++; $display("FAIL cont_onehot got=%0d want=0", multi); end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = '0;  req_wdata[i] = '0;  req_be[i] = '0;
      end
      test_reset();
      test_single_read();
      test_single_write();
      test_misaligned();
      test_dropped_req();
      test_reset_mid();
      test_contention();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
